// File: rtl/mem_reverse_sequencer_if.sv
// Bus bundle for mem_reverse_sequencer: control handshake, source read port and destination write port.
// The sequencer takes the master side; the memories/driver take the slave side.
interface mem_reverse_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              start;
  logic              abort;
  logic              src_rd_en;
  logic [ADDR_W-1:0] src_rd_addr;
  logic [DATA_W-1:0] src_rd_data;
  logic              dst_wr_en;
  logic [ADDR_W-1:0] dst_wr_addr;
  logic [DATA_W-1:0] dst_wr_data;
  logic              busy;
  logic              done;

  modport master (
    input  start,
    input  abort,
    input  src_rd_data,
    output src_rd_en,
    output src_rd_addr,
    output dst_wr_en,
    output dst_wr_addr,
    output dst_wr_data,
    output busy,
    output done
  );

  modport slave (
    output start,
    output abort,
    output src_rd_data,
    input  src_rd_en,
    input  src_rd_addr,
    input  dst_wr_en,
    input  dst_wr_addr,
    input  dst_wr_data,
    input  busy,
    input  done
  );
endinterface

// File: rtl/mem_reverse_sequencer.sv
// Clocked reverse-copy sequencer: dst[i] = src[DST_DEPTH-1-i], out-of-window entries get FILL.
// One issue per cycle from a synchronous-read source; writes trail issues by one cycle.

module mem_reverse_sequencer_chk #(
  parameter int ADDR_W    = 4,
  parameter int DST_DEPTH = 10
) (
  input logic              clk,
  input logic              rst_n,
  input logic              busy,
  input logic              done,
  input logic              src_rd_en,
  input logic              dst_wr_en,
  input logic [ADDR_W-1:0] dst_wr_addr
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DST_DEPTH - 1);

  busy_done_exclusive_a: assert property (@(posedge clk) disable iff (!rst_n) !(busy && done));
  read_only_when_busy_a: assert property (@(posedge clk) disable iff (!rst_n) src_rd_en |-> busy);
  write_addr_in_range_a: assert property (@(posedge clk) disable iff (!rst_n) dst_wr_en |-> (dst_wr_addr <= LAST_ADDR));
  done_single_pulse_a:   assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);
endmodule

module mem_reverse_sequencer #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int SRC_LO    = 2,
  parameter int SRC_HI    = 5,
  parameter int DST_DEPTH = 10,
  parameter int FILL      = 100
) (
  input logic                     clk,
  input logic                     rst_n,
  mem_reverse_sequencer_if.master bus
);
  // One extra index bit keeps LAST-cnt from wrapping into the window compare.
  localparam int IDX_W = ADDR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DST_DEPTH - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DST_DEPTH - 1);
  localparam logic [IDX_W-1:0]  LO_IDX   = IDX_W'(SRC_LO);
  localparam logic [IDX_W-1:0]  HI_IDX   = IDX_W'(SRC_HI);
  localparam logic [DATA_W-1:0] FILL_VAL = DATA_W'(FILL);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [ADDR_W-1:0] cnt_r;
  logic [ADDR_W-1:0] cnt_nxt_s;
  logic              v1_r;
  logic              w1_r;
  logic [ADDR_W-1:0] a1_r;
  logic              issue_s;
  logic              cancel_s;
  logic              in_win_s;
  logic [IDX_W-1:0]  sidx_s;

  // Mirrored source index and window test for the current issue slot
  always_comb begin
    issue_s  = (state_r == ST_RUN);
    cancel_s = bus.abort && ((state_r == ST_RUN) || (state_r == ST_DRAIN));
    sidx_s   = LAST_IDX - {1'b0, cnt_r};
    in_win_s = issue_s && (sidx_s >= LO_IDX) && (sidx_s <= HI_IDX);
  end

  // Next-state selection; abort only acts while a pass is in flight
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == LAST_CNT) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (bus.abort) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Issue counter: cleared on start or cancel, saturates at the last entry
  always_comb begin
    cnt_nxt_s = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          cnt_nxt_s = {ADDR_W{1'b0}};
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          cnt_nxt_s = {ADDR_W{1'b0}};
        end else if (cnt_r == LAST_CNT) begin
          cnt_nxt_s = cnt_r;
        end else begin
          cnt_nxt_s = cnt_r + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (bus.abort) begin
          cnt_nxt_s = {ADDR_W{1'b0}};
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_DONE: cnt_nxt_s = cnt_r;
      default: cnt_nxt_s = {ADDR_W{1'b0}};
    endcase
  end

  // Control state and issue counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Stage 1: remember what was issued so the write lines up with the read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r <= 1'b0;
      a1_r <= {ADDR_W{1'b0}};
      w1_r <= 1'b0;
    end else if (issue_s && !cancel_s) begin
      v1_r <= 1'b1;
      a1_r <= cnt_r;
      w1_r <= in_win_s;
    end else begin
      v1_r <= 1'b0;
      a1_r <= {ADDR_W{1'b0}};
      w1_r <= 1'b0;
    end
  end

  // Bus outputs; write data is forced to zero whenever no write is presented
  always_comb begin
    bus.src_rd_en = in_win_s;
    if (in_win_s) begin
      bus.src_rd_addr = sidx_s[ADDR_W-1:0];
    end else begin
      bus.src_rd_addr = {ADDR_W{1'b0}};
    end
    bus.dst_wr_en   = v1_r;
    bus.dst_wr_addr = a1_r;
    if (!v1_r) begin
      bus.dst_wr_data = {DATA_W{1'b0}};
    end else if (w1_r) begin
      bus.dst_wr_data = bus.src_rd_data;
    end else begin
      bus.dst_wr_data = FILL_VAL;
    end
    bus.busy = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    bus.done = (state_r == ST_DONE);
  end

  mem_reverse_sequencer_chk #(
    .ADDR_W    (ADDR_W),
    .DST_DEPTH (DST_DEPTH)
  ) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .busy        (bus.busy),
    .done        (bus.done),
    .src_rd_en   (bus.src_rd_en),
    .dst_wr_en   (bus.dst_wr_en),
    .dst_wr_addr (bus.dst_wr_addr)
  );
endmodule

// File: tb/tb_mem_reverse_sequencer.sv
// Bench for mem_reverse_sequencer: two instances (default window and full window) share start/abort,
// and every cycle is compared against a pass-offset model derived from the sequencing rules.
module tb_mem_reverse_sequencer;
  localparam int DW     = 8;
  localparam int AW     = 4;
  localparam int DEPTH  = 10;
  localparam int FILL_V = 100;
  localparam int BIG    = 32'h7fff_ffff;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_reverse_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
  mem_reverse_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

  mem_reverse_sequencer #(.DATA_W(DW), .ADDR_W(AW), .SRC_LO(2), .SRC_HI(5), .DST_DEPTH(DEPTH), .FILL(FILL_V))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  mem_reverse_sequencer #(.DATA_W(DW), .ADDR_W(AW), .SRC_LO(0), .SRC_HI(9), .DST_DEPTH(DEPTH), .FILL(FILL_V))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  logic [DW-1:0] src_a [16];
  logic [DW-1:0] src_b [16];
  logic [DW-1:0] dst_a [16];
  logic [DW-1:0] dst_b [16];
  logic [DW-1:0] exp_a [10];

  // Synchronous-read source RAMs and destination capture
  always @(posedge clk) begin
    if (bus_a.src_rd_en) bus_a.src_rd_data <= src_a[bus_a.src_rd_addr];
    if (bus_b.src_rd_en) bus_b.src_rd_data <= src_b[bus_b.src_rd_addr];
    if (bus_a.dst_wr_en) dst_a[bus_a.dst_wr_addr] <= bus_a.dst_wr_data;
    if (bus_b.dst_wr_en) dst_b[bus_b.dst_wr_addr] <= bus_b.dst_wr_data;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int k_run = -1;   // first RUN cycle of the current pass, -1 when none
  int end_c = BIG;  // first cycle after an aborted pass

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit in_window(input bit is_b, input int idx);
    int lo;
    int hi;
    lo = is_b ? 0 : 2;
    hi = is_b ? 9 : 5;
    return (idx >= lo) && (idx <= hi);
  endfunction

  function automatic logic [DW-1:0] exp_val(input bit is_b, input int i);
    int sidx;
    sidx = DEPTH - 1 - i;
    if (!in_window(is_b, sidx)) return DW'(FILL_V);
    return is_b ? src_b[sidx] : src_a[sidx];
  endfunction

  task automatic check_outputs(input string nm, input bit is_b, input logic rd_en, input logic [AW-1:0] rd_addr,
                               input logic wr_en, input logic [AW-1:0] wr_addr, input logic [DW-1:0] wr_data,
                               input logic busy, input logic done);
    bit act;
    int off;
    bit e_busy, e_done, e_rd, e_wr;
    int e_rd_addr;
    act = (k_run >= 0) && (cyc >= k_run) && (cyc < end_c) && (cyc - k_run <= DEPTH + 1);
    off = cyc - k_run;
    e_busy = act && (off <= DEPTH);
    e_done = act && (off == DEPTH + 1);
    e_rd   = act && (off <= DEPTH - 1) && in_window(is_b, DEPTH - 1 - off);
    e_rd_addr = e_rd ? (DEPTH - 1 - off) : 0;
    e_wr   = act && (off >= 1) && (off <= DEPTH);
    check_eq({nm, ".busy"}, 32'(busy), 32'(e_busy));
    check_eq({nm, ".done"}, 32'(done), 32'(e_done));
    check_eq({nm, ".src_rd_en"}, 32'(rd_en), 32'(e_rd));
    check_eq({nm, ".src_rd_addr"}, 32'(rd_addr), 32'(e_rd_addr));
    check_eq({nm, ".dst_wr_en"}, 32'(wr_en), 32'(e_wr));
    if (e_wr) begin
      check_eq({nm, ".dst_wr_addr"}, 32'(wr_addr), 32'(off - 1));
      check_eq({nm, ".dst_wr_data"}, 32'(wr_data), 32'(exp_val(is_b, off - 1)));
    end
  endtask

  task automatic check_quiet(input string nm);
    check_eq({nm, ".a_quiet"}, 32'({bus_a.src_rd_en, bus_a.src_rd_addr, bus_a.dst_wr_en, bus_a.dst_wr_addr,
                                    bus_a.dst_wr_data, bus_a.busy, bus_a.done}), 32'd0);
    check_eq({nm, ".b_quiet"}, 32'({bus_b.src_rd_en, bus_b.src_rd_addr, bus_b.dst_wr_en, bus_b.dst_wr_addr,
                                    bus_b.dst_wr_data, bus_b.busy, bus_b.done}), 32'd0);
  endtask

  // Apply start/abort for the current cycle, advance one clock and compare both instances.
  task automatic step(input bit st, input bit ab);
    bit idle, in_flight;
    idle      = !((k_run >= 0) && (cyc >= k_run) && (cyc < end_c) && (cyc - k_run <= DEPTH + 1));
    in_flight = (k_run >= 0) && (cyc >= k_run) && (cyc < end_c) && (cyc - k_run <= DEPTH);
    if (rst_n) begin
      if (st && idle) begin
        k_run = cyc + 1;
        end_c = BIG;
      end else if (ab && in_flight) begin
        end_c = cyc + 1;
      end
    end
    bus_a.start = st;
    bus_b.start = st;
    bus_a.abort = ab;
    bus_b.abort = ab;
    @(posedge clk);
    #1;
    cyc++;
    check_outputs("a", 1'b0, bus_a.src_rd_en, bus_a.src_rd_addr, bus_a.dst_wr_en, bus_a.dst_wr_addr,
                  bus_a.dst_wr_data, bus_a.busy, bus_a.done);
    check_outputs("b", 1'b1, bus_b.src_rd_en, bus_b.src_rd_addr, bus_b.dst_wr_en, bus_b.dst_wr_addr,
                  bus_b.dst_wr_data, bus_b.busy, bus_b.done);
  endtask

  task automatic idle_until(input int target);
    while (cyc < target) step(1'b0, 1'b0);
  endtask

  initial begin
    int k;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    bus_a.abort = 1'b0;
    bus_b.abort = 1'b0;
    for (int i = 0; i < 16; i++) begin
      src_a[i] = 8'h00;
      src_b[i] = DW'(i + 1);
    end
    for (int i = 2; i <= 5; i++) src_a[i] = DW'(8'hA0 + i);
    for (int i = 0; i < 10; i++) exp_a[i] = 8'h64;
    exp_a[4] = 8'hA5;
    exp_a[5] = 8'hA4;
    exp_a[6] = 8'hA3;
    exp_a[7] = 8'hA2;

    // Reset state
    #1;
    check_quiet("reset");
    repeat (3) step(1'b0, 1'b0);
    #2 rst_n = 1'b1;
    repeat (2) step(1'b0, 1'b0);

    // Directed pass with default window and full-window instance
    step(1'b1, 1'b0);
    k = cyc;
    idle_until(k + 14);
    for (int i = 0; i < DEPTH; i++) begin
      check_eq("dst_a_content", 32'(dst_a[i]), 32'(exp_a[i]));
      check_eq("dst_b_content", 32'(dst_b[i]), 32'(DEPTH - i));
    end

    // start re-pulsed while busy and in DONE
    step(1'b1, 1'b0);
    k = cyc;
    idle_until(k + 3);
    step(1'b1, 1'b0);
    idle_until(k + 11);
    step(1'b1, 1'b0);
    idle_until(k + 26);

    // start held: back-to-back passes
    repeat (30) step(1'b1, 1'b0);
    idle_until(cyc + 14);

    // abort mid-run, then a normal pass
    step(1'b1, 1'b0);
    k = cyc;
    idle_until(k + 5);
    step(1'b0, 1'b1);
    idle_until(k + 9);
    step(1'b1, 1'b0);
    idle_until(cyc + 14);

    // start and abort together in IDLE: start wins
    step(1'b1, 1'b1);
    idle_until(cyc + 14);

    // abort during DONE is ignored
    step(1'b1, 1'b0);
    k = cyc;
    idle_until(k + 11);
    step(1'b0, 1'b1);
    idle_until(k + 16);

    // asynchronous reset mid-pass
    step(1'b1, 1'b0);
    k = cyc;
    idle_until(k + 6);
    #2 rst_n = 1'b0;
    #1;
    check_quiet("async_reset");
    k_run = -1;
    end_c = BIG;
    repeat (2) step(1'b0, 1'b0);
    #2 rst_n = 1'b1;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    idle_until(cyc + 14);

    // Randomized rounds with fresh source contents
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) begin
        src_a[i] = DW'($urandom);
        src_b[i] = DW'($urandom);
      end
      for (int n = 0; n < 80; n++) begin
        step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
      end
      idle_until(cyc + 14);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
